alu_exec: RTL and testbench

- Execute stage of the 16-bit CPU pipeline; consumes the registered operand pair and enable produced by the operand-select stage.
- Performs one ALU operation per accepted enable and registers result, flags and a register-write strobe for writeback.
- Single-cycle ops have 1-cycle latency; MUL is a multi-cycle shift-add sequencer that asserts busy so the controller stalls issue.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/alu_exec_if.sv | 17 +
 rtl/alu_mul_seq.sv | 59 +++++
 rtl/alu_exec.sv | 90 +++++++++
 tb/tb_alu_exec.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, flag bit positions and execute-stage states shared across the CPU.
package cpu_pkg;
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam logic [3:0] OP_CMP   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;
    typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: operand/result bundle between operand-select, execute and writeback.
interface alu_exec_if #(parameter int WIDTH = 16);
    logic             en_in;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_out;
    logic [3:0]       flags;
    logic             reg_we;
    logic             en_out;
    logic             busy;
    logic             drop;
    modport master (output en_in, alu_a, alu_b, alu_op,
                    input  alu_out, flags, reg_we, en_out, busy, drop);
    modport slave  (input  en_in, alu_a, alu_b, alu_op,
                    output alu_out, flags, reg_we, en_out, busy, drop);
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one multiplier bit per edge, done on its last MUL edge.
module alu_mul_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 2);
    state_t state, state_n;
    logic [2*WIDTH-1:0] mcand, acc, pp0, pp1;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0] cnt, cnt_n;
    assign cnt_n = cnt + 1'b1;
    // The final edge folds in the top two bits so the product lands one edge
    // earlier than a plain bit-per-edge loop would allow.
    assign pp0     = mplier[cnt]   ? mcand << cnt   : '0;
    assign pp1     = mplier[cnt_n] ? mcand << cnt_n : '0;
    assign product = acc + pp0 + pp1;
    assign busy    = state == ST_MUL;
    always_comb begin
        state_n = state;
        done    = 1'b0;
        if (state == ST_IDLE && start) state_n = ST_MUL;
        if (state == ST_MUL && cnt == LAST) begin
            state_n = ST_IDLE;
            done    = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && start) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else if (busy) begin
                acc <= acc + pp0;
                cnt <= cnt_n;
            end
        end
    end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute stage; single-cycle ALU, sequenced MUL, registered result/flags/strobes.
module alu_exec
    import cpu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input logic       clk,
    input logic       rst,
    alu_exec_if.slave bus
);
    logic [WIDTH:0]     sum, dif, sll_x, srl_x, sra_x;
    logic [WIDTH-1:0]   a, b, res;
    logic [3:0]         shamt, nf, mf;
    logic [2*WIDTH-1:0] product;
    logic               c, v, accept, writes, sets_flags, mul_busy, mul_done;
    assign a          = bus.alu_a;
    assign b          = bus.alu_b;
    assign shamt      = b[3:0];
    assign sum        = {1'b0, a} + {1'b0, b};
    assign dif        = {1'b0, a} - {1'b0, b};
    // One guard bit on each shift catches the last bit shifted out (0 for amount 0).
    assign sll_x      = {1'b0, a} << shamt;
    assign srl_x      = {a, 1'b0} >> shamt;
    assign sra_x      = $signed({a, 1'b0}) >>> shamt;
    assign accept     = bus.en_in & ~mul_busy;
    assign writes     = bus.alu_op <= OP_PASSB;
    assign sets_flags = bus.alu_op <= OP_CMP;
    assign bus.busy   = mul_busy;
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (bus.alu_op)
            OP_ADD:         begin res = sum[WIDTH-1:0]; c = sum[WIDTH];
                                  v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]); end
            OP_SUB, OP_CMP: begin res = dif[WIDTH-1:0]; c = dif[WIDTH];
                                  v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]); end
            OP_AND:         res = a & b;
            OP_OR:          res = a | b;
            OP_XOR:         res = a ^ b;
            OP_NOT:         res = ~a;
            OP_SLL:         begin res = sll_x[WIDTH-1:0]; c = sll_x[WIDTH]; end
            OP_SRL:         begin res = srl_x[WIDTH:1];   c = srl_x[0];     end
            OP_SRA:         begin res = sra_x[WIDTH:1];   c = sra_x[0];     end
            OP_PASSB:       res = b;
            default:        res = '0;
        endcase
        nf      = '0;
        nf[F_Z] = res == '0;
        nf[F_N] = res[WIDTH-1];
        nf[F_C] = c;
        nf[F_V] = v;
        mf      = '0;
        mf[F_Z] = product[WIDTH-1:0] == '0;
        mf[F_N] = product[WIDTH-1];
        mf[F_C] = |product[2*WIDTH-1:WIDTH];
        mf[F_V] = |product[2*WIDTH-1:WIDTH];
    end
    alu_mul_seq #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && bus.alu_op == OP_MUL),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.alu_out <= '0;
            bus.flags   <= '0;
            bus.reg_we  <= 1'b0;
            bus.en_out  <= 1'b0;
            bus.drop    <= 1'b0;
        end else begin
            bus.en_out <= mul_done | (accept && bus.alu_op != OP_MUL);
            bus.reg_we <= mul_done | (accept && writes);
            bus.drop   <= bus.en_in & mul_busy;
            if (mul_done) begin
                bus.alu_out <= product[WIDTH-1:0];
                bus.flags   <= mf;
            end else if (accept) begin
                if (writes) bus.alu_out <= res;
                if (sets_flags) bus.flags <= nf;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vectors with literal expectations plus a per-cycle behavioural model.
module tb_alu_exec;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    alu_exec_if #(.WIDTH(16)) bus ();
    alu_exec #(.WIDTH(16), .MUL_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result of one operation from the opcode's arithmetic meaning.
    function automatic void model_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] r, output logic [3:0] f,
                                      output bit wr, output bit fl);
        int    ia = int'(a);
        int    ib = int'(b);
        int    sa = int'($signed(a));
        int    sb = int'($signed(b));
        int    s  = int'(b[3:0]);
        longint p;
        logic  c = 1'b0;
        logic  v = 1'b0;
        r  = 16'h0;
        wr = 1'b1;
        fl = 1'b1;
        case (op)
            4'd0:  begin r = 16'(ia + ib); c = (ia + ib) > 65535; v = (sa + sb) > 32767 || (sa + sb) < -32768; end
            4'd1, 4'd10: begin r = 16'(ia - ib); c = ia < ib; v = (sa - sb) > 32767 || (sa - sb) < -32768; wr = op == 4'd1; end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  begin r = a << s; c = s > 0 && a[16 - s]; end
            4'd7:  begin r = a >> s; c = s > 0 && a[s - 1]; end
            4'd8:  begin r = 16'($signed(a) >>> s); c = s > 0 && a[s - 1]; end
            4'd9:  r = b;
            4'd11: begin p = longint'(ia) * longint'(ib); r = p[15:0]; c = p > 65535; v = c; end
            default: begin wr = 1'b0; fl = 1'b0; end
        endcase
        f = {r == 16'h0, r[15], c, v};
    endfunction

    logic [15:0] m_out = '0, mul_r = '0, tr;
    logic [3:0]  m_flags = '0, mul_f = '0, tf;
    bit          m_en = 0, m_we = 0, m_drop = 0, m_busy = 0, was_busy, twr, tfl;
    int          cyc = 0, due = -1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out = '0; m_flags = '0; m_en = 0; m_we = 0; m_drop = 0; m_busy = 0; due = -1; cyc = 0;
        end else begin
            was_busy = m_busy;
            cyc++;
            m_en = 0; m_we = 0; m_drop = 0;
            if (cyc == due) begin
                m_out = mul_r; m_flags = mul_f; m_en = 1; m_we = 1; m_busy = 0; due = -1;
            end
            if (bus.en_in) begin
                if (was_busy) m_drop = 1;
                else if (bus.alu_op == 4'd11) begin
                    model_alu(bus.alu_op, bus.alu_a, bus.alu_b, mul_r, mul_f, twr, tfl);
                    m_busy = 1;
                    due = cyc + 15;
                end else begin
                    model_alu(bus.alu_op, bus.alu_a, bus.alu_b, tr, tf, twr, tfl);
                    m_en = 1;
                    if (twr) begin m_we = 1; m_out = tr; end
                    if (tfl) m_flags = tf;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_alu_out", 32'(bus.alu_out), 32'(m_out));
        chk("m_flags",   32'(bus.flags),   32'(m_flags));
        chk("m_en_out",  32'(bus.en_out),  32'(m_en));
        chk("m_reg_we",  32'(bus.reg_we),  32'(m_we));
        chk("m_busy",    32'(bus.busy),    32'(m_busy));
        chk("m_drop",    32'(bus.drop),    32'(m_drop));
    end

    // Called on a falling edge; returns on the falling edge after the sampling edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.en_in = 1'b1; bus.alu_op = op; bus.alu_a = a; bus.alu_b = b;
        @(negedge clk);
        bus.en_in = 1'b0;
    endtask

    task automatic wait_done(output int n, output int nb);
        n = 0; nb = 0;
        while (!bus.en_out && n < 40) begin
            if (bus.busy) nb++;
            @(negedge clk);
            n++;
        end
        if (!bus.en_out) chk("mul_timeout", 32'(bus.en_out), 32'd1);
    endtask

    task automatic chk_outs(input string name, input logic [15:0] o, input logic [3:0] f, input bit e, input bit w);
        chk({name, "_out"},   32'(bus.alu_out), 32'(o));
        chk({name, "_flags"}, 32'(bus.flags),   32'(f));
        chk({name, "_en"},    32'(bus.en_out),  32'(e));
        chk({name, "_we"},    32'(bus.reg_we),  32'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, nb, ens;
        bus.en_in = 1'b0; bus.alu_op = '0; bus.alu_a = '0; bus.alu_b = '0;
        #12;
        chk_outs("reset", 16'h0, 4'h0, 0, 0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_drop", 32'(bus.drop), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(4'd0, 16'h7FFF, 16'h0001);
        chk_outs("add", 16'h8000, 4'b0101, 1, 1);
        @(negedge clk);
        chk("add_en_pulse", 32'(bus.en_out), 32'd0);
        issue(4'd1, 16'h0003, 16'h0005);
        chk_outs("sub", 16'hFFFE, 4'b0110, 1, 1);
        issue(4'd10, 16'h0005, 16'h0005);
        chk_outs("cmp", 16'hFFFE, 4'b1000, 1, 0);
        issue(4'd8, 16'h8004, 16'h0002);
        chk_outs("sra", 16'hE001, 4'b0100, 1, 1);
        issue(4'd6, 16'h8001, 16'h0001);
        chk_outs("sll", 16'h0002, 4'b0010, 1, 1);
        issue(4'd12, 16'h1111, 16'h2222);
        chk_outs("reserved", 16'h0002, 4'b0010, 1, 0);
        issue(4'd7, 16'h8003, 16'h0004);
        issue(4'd2, 16'hF0F0, 16'h3C3C);
        issue(4'd3, 16'h0000, 16'h0000);
        issue(4'd5, 16'h00FF, 16'h0000);
        issue(4'd9, 16'h0000, 16'h8000);
        issue(4'd11, 16'h0123, 16'h0045);
        wait_done(n, nb);
        chk("mul1_latency", 32'(n), 32'd15);
        chk("mul1_busy_cycles", 32'(nb), 32'd15);
        chk_outs("mul1", 16'h4E6F, 4'b0000, 1, 1);
        @(negedge clk);
        issue(4'd11, 16'hFFFF, 16'h0002);
        wait_done(n, nb);
        chk_outs("mul2", 16'hFFFE, 4'b0111, 1, 1);
        @(negedge clk);
        issue(4'd11, 16'h0010, 16'h0003);
        repeat (4) @(negedge clk);
        issue(4'd0, 16'h0001, 16'h0001);
        chk("drop_pulse", 32'(bus.drop), 32'd1);
        wait_done(n, nb);
        chk("mul3_latency", 32'(n + 5), 32'd15);
        chk_outs("mul3", 16'h0030, 4'b0000, 1, 1);
        issue(4'd0, 16'h0001, 16'h0002);
        chk_outs("back2back", 16'h0003, 4'b0000, 1, 1);
        chk("drop_once", 32'(bus.drop), 32'd0);
        issue(4'd11, 16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_outs("midrst", 16'h0, 4'h0, 0, 0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ens = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.en_out) ens++;
        end
        chk("no_en_after_rst", 32'(ens), 32'd0);
        issue(4'd4, 16'hF0F0, 16'h0FF0);
        chk_outs("xor", 16'hFF00, 4'b0100, 1, 1);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
